// File: rtl/vec_pkg.sv
// Shared vector-datapath definitions: lane geometry, the vector type used by
// alu_vec, and the load-unit state encoding.
package vec_pkg;

    localparam int unsigned ELEMENT = 16;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned CNT_W   = $clog2(ELEMENT + 1);

    typedef logic [ELEMENT-1:0][WIDTH-1:0] vec_t;

    typedef enum logic [1:0] {
        VLD_IDLE,
        VLD_RUN,
        VLD_DONE
    } vld_state_t;

endpackage

// File: rtl/vec_load_unit_if.sv
// Scalar data-memory read port between the vector load unit and data memory.
interface vec_load_unit_if;
    import vec_pkg::*;

    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [WIDTH-1:0]  mem_rdata;

    modport master (output mem_re, mem_addr, input mem_ready, mem_rdata);
    modport slave  (input mem_re, mem_addr, output mem_ready, mem_rdata);

endinterface

// File: rtl/vec_addr_gen.sv
// Strided read-address generator: latches base/stride/count at load and walks
// a wrapping address accumulator, one step per accepted request.
module vec_addr_gen
    import vec_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              bcast,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              last_issued
);

    logic [ADDR_W-1:0] stride_q;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  issue_n_q;

    // The accumulator holds the latched base as its seed, so base needs no separate copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            stride_q  <= '0;
            issue_cnt <= '0;
            issue_n_q <= '0;
        end else if (load) begin
            addr      <= base;
            stride_q  <= stride;
            issue_cnt <= '0;
            issue_n_q <= bcast ? CNT_W'(1) : CNT_W'(ELEMENT);
        end else if (advance && !last_issued) begin
            addr      <= addr + stride_q;
            issue_cnt <= issue_cnt + 1'b1;
        end
    end

    assign last_issued = (issue_cnt >= issue_n_q);

endmodule

// File: rtl/vec_load_unit.sv
// Fills one double-buffered vector operand from scalar memory with a strided
// (or broadcast) halfword fetch, publishing the whole vector on completion.
module vec_load_unit
    import vec_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              bcast,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    vec_load_unit_if.master   mem,
    output logic              busy,
    output logic              done,
    output vec_t              vector_out
);

    vld_state_t       state;
    logic             bcast_q;
    logic             accepted;
    logic [CNT_W-1:0] recv_cnt;
    vec_t             shadow;
    vec_t             shadow_nxt;
    logic             load;
    logic             advance;
    logic             last_issued;
    logic             last_datum;

    assign load       = (state == VLD_IDLE) && start;
    assign mem.mem_re = (state == VLD_RUN) && !last_issued;
    assign advance    = mem.mem_re && mem.mem_ready;
    assign last_datum = accepted && (bcast_q || recv_cnt == CNT_W'(ELEMENT - 1));

    vec_addr_gen u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .bcast       (bcast),
        .base        (base_addr),
        .stride      (stride),
        .advance     (advance),
        .addr        (mem.mem_addr),
        .last_issued (last_issued)
    );

    always_comb begin
        shadow_nxt = shadow;
        if (accepted) begin
            for (int unsigned i = 0; i < ELEMENT; i++) begin
                if (bcast_q || recv_cnt == CNT_W'(i)) begin
                    shadow_nxt[i] = mem.mem_rdata;
                end
            end
        end
    end

    // The final datum is merged on the way into vector_out so DONE publishes the complete vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= VLD_IDLE;
            bcast_q    <= 1'b0;
            accepted   <= 1'b0;
            recv_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            shadow     <= '0;
            vector_out <= '0;
        end else begin
            case (state)
                VLD_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= VLD_RUN;
                        busy     <= 1'b1;
                        bcast_q  <= bcast;
                        recv_cnt <= '0;
                        accepted <= 1'b0;
                    end
                end
                VLD_RUN: begin
                    accepted <= advance;
                    shadow   <= shadow_nxt;
                    if (accepted) begin
                        recv_cnt <= recv_cnt + 1'b1;
                    end
                    if (last_datum) begin
                        state      <= VLD_DONE;
                        vector_out <= shadow_nxt;
                        done       <= 1'b1;
                    end
                end
                VLD_DONE: begin
                    state <= VLD_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= VLD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_load_unit.sv
// Self-checking bench for vec_load_unit: directed scenarios plus randomized
// loads checked against an address/latency/data reference model.
module tb_vec_load_unit;
    import vec_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        bcast;
    logic [15:0] base_addr;
    logic [15:0] stride;
    logic        busy;
    logic        done;
    vec_t        vector_out;

    vec_load_unit_if mif ();

    vec_load_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bcast      (bcast),
        .base_addr  (base_addr),
        .stride     (stride),
        .mem        (mif.master),
        .busy       (busy),
        .done       (done),
        .vector_out (vector_out)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];

    always @(posedge clk) begin
        if (mif.mem_re && mif.mem_ready) mif.mem_rdata <= mem[mif.mem_addr];
    end

    int   checks = 0;
    int   failures = 0;
    vec_t prev_vec = '0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic vec_t model_vec(input logic [15:0] b, input logic [15:0] s, input logic bc);
        vec_t v;
        for (int i = 0; i < 16; i++) begin
            logic [15:0] a;
            a = bc ? b : 16'(b + 16'(i) * s);
            v[i] = mem[a];
        end
        return v;
    endfunction

    // One load request. Stall window, a spurious start and a reset can be placed at given cycles (0 = none).
    task automatic do_load(input logic [15:0] b, input logic [15:0] s, input logic bc,
                           input int stall_at, input int stall_len, input int start2_at, input int rst_at);
        int   n;
        int   issued;
        int   last_issue;
        bit   finished;
        vec_t expv;
        logic [15:0] ea;
        n = bc ? 1 : 16;
        issued = 0;
        last_issue = -1;
        finished = 0;
        expv = model_vec(b, s, bc);
        start = 1'b1; bcast = bc; base_addr = b; stride = s; mif.mem_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; bcast = 1'($urandom); base_addr = 16'($urandom); stride = 16'($urandom);
        for (int k = 1; k <= 80; k++) begin
            mif.mem_ready = !(k >= stall_at && k < stall_at + stall_len);
            if (k == start2_at) begin
                start = 1'b1;
                base_addr = b + 16'h0100;
            end
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", 256'(busy), 256'(0));
                check("rst_mem_re", 256'(mif.mem_re), 256'(0));
                check("rst_done", 256'(done), 256'(0));
                check("rst_vec", 256'(vector_out), 256'(0));
                prev_vec = '0;
                start = 1'b0;
                mif.mem_ready = 1'b1;
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            if (k == 1) check("busy_rise", 256'(busy), 256'(1));
            if (issued < n) begin
                ea = 16'(b + 16'(issued) * s);
                check("req_re", 256'(mif.mem_re), 256'(1));
                check("req_addr", 256'(mif.mem_addr), 256'(ea));
                if (mif.mem_ready) begin
                    issued++;
                    if (issued == n) last_issue = k;
                end
            end else if (k <= last_issue + 2) begin
                check("req_idle", 256'(mif.mem_re), 256'(0));
            end
            if (last_issue >= 0 && k == last_issue + 2) begin
                check("done_pulse", 256'(done), 256'(1));
                check("vec_data", 256'(vector_out), 256'(expv));
                prev_vec = expv;
            end else if (last_issue < 0 || k < last_issue + 2) begin
                check("done_early", 256'(done), 256'(0));
                check("vec_hold", 256'(vector_out), 256'(prev_vec));
            end else if (k == last_issue + 3) begin
                check("done_clear", 256'(done), 256'(0));
                check("busy_fall", 256'(busy), 256'(0));
                finished = 1;
                break;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (!finished) check("timeout", 256'(0), 256'(1));
    endtask

    initial begin
        vec_t        kv;
        logic [255:0] got_sum;
        logic [255:0] exp_sum;
        vec_t        bvec;
        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
        for (int i = 0; i < 16; i++) mem[16'h0100 + i] = 16'h1000 + 16'(i);
        mem[16'h0040] = 16'h0064;

        rst_n = 1'b0; start = 1'b0; bcast = 1'b0; base_addr = '0; stride = '0;
        mif.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_re", 256'(mif.mem_re), 256'(0));
        check("reset_addr", 256'(mif.mem_addr), 256'(0));
        check("reset_busy", 256'(busy), 256'(0));
        check("reset_done", 256'(done), 256'(0));
        check("reset_vec", 256'(vector_out), 256'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full load, then broadcast, then wrapping stride.
        do_load(16'h0100, 16'h0001, 1'b0, 0, 0, 0, 0);
        do_load(16'h0040, 16'h0003, 1'b1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) kv[i] = 16'($urandom);
        for (int i = 0; i < 16; i++) begin
            bvec = vector_out;
            got_sum[i*16 +: 16] = bvec[i] + kv[i];
            exp_sum[i*16 +: 16] = 16'h0064 + kv[i];
        end
        check("alu_add", got_sum, exp_sum);
        do_load(16'hFFF0, 16'h0004, 1'b0, 0, 0, 0, 0);

        // Back-pressure, ignored start while busy, reset mid-load then fresh load.
        do_load(16'h0100, 16'h0001, 1'b0, 5, 3, 0, 0);
        do_load(16'h0100, 16'h0001, 1'b0, 0, 0, 7, 0);
        do_load(16'h0200, 16'h0002, 1'b0, 0, 0, 0, 9);
        do_load(16'h0300, 16'h0005, 1'b0, 0, 0, 0, 0);

        for (int t = 0; t < 8; t++) begin
            logic [15:0] rb;
            logic [15:0] rs;
            logic        rbc;
            rb  = 16'($urandom);
            rs  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            rbc = ($urandom_range(0, 3) == 0);
            do_load(rb, rs, rbc, $urandom_range(1, 14), $urandom_range(0, 4), 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vec_load_unit.md
# vec_load_unit

Fills one 16-lane × 16-bit vector operand from scalar data memory for the vector ALU stage, one halfword per cycle, using a strided address sequence. It sits directly upstream of `alu_vec`, between data memory and the vector operand latch. It can also run a broadcast fetch: one word is read and replicated across all lanes. Output vectors are double-buffered, so the ALU-side vector changes only on completion.

## Interface
- `ELEMENT`, 16: number of lanes, which is also the number of halfword reads per full load.
- `WIDTH`, 16: lane width in bits, equal to the memory data width.
- `ADDR_W`, 16: memory address width.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a load; sampled only in IDLE.
- `bcast`  in  1  sampled with `start`; 1 means fetch one word and replicate it to all lanes.
- `base_addr`  in  ADDR_W  address of lane 0, sampled with `start`.
- `stride`  in  ADDR_W  address increment between lanes, sampled with `start`.
- `mem_ready`  in  1  memory accepts the request presented this cycle.
- `mem_re`  out  1  read request.
- `mem_addr`  out  ADDR_W  read address.
- `mem_rdata`  in  WIDTH  read data, valid exactly one cycle after an accepted request.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when `vector_out` has just been updated.
- `vector_out`  out  ELEMENT×WIDTH (packed `[ELEMENT-1:0][WIDTH-1:0]`)  lane i in `vector_out[i]`; feeds `alu_vec.vectorA`/`vectorB`.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: issues requests and captures returned data.
  - DONE: one cycle in which the completed vector is published.
- Transitions: IDLE→RUN on `start`. RUN→DONE in the cycle after the last datum is captured. DONE→IDLE unconditionally.
- Parameters latched with `start`: base, stride and `bcast`. The request count N is ELEMENT when `bcast`=0 and 1 when `bcast`=1.
- Request generation:
  - `mem_re` = (state==RUN) && (issue_cnt < N).
  - `mem_addr` = base + issue_cnt·stride, computed modulo 2^ADDR_W. Implement as a running address accumulator that wraps silently; no multiplier.
  - An accepted request (`mem_re && mem_ready`) increments issue_cnt.
  - `mem_re`/`mem_addr` stay stable while `mem_ready`=0.
- Capture:
  - A registered `accepted` flag marks the cycle in which `mem_rdata` is valid.
  - In that cycle the data is written to shadow lane recv_cnt and recv_cnt increments.
  - In broadcast mode the single datum is written to all ELEMENT shadow lanes.
- Publish: on entering DONE, the shadow buffer is copied to `vector_out` and `done` pulses. `vector_out` holds its value at all other times.
- `start` while busy is ignored; the parameter latches do not change.
- `stride`=0 is legal: it gives N reads of the same address.
- Reset, including assertion mid-operation:
  - state→IDLE; counters, `accepted`, `mem_re`, `busy` and `done` go to 0.
  - `vector_out` and the shadow buffer go to all-zero.
  - In-flight read data is discarded and there is no partial publish.

## Timing
- Reset values of outputs: `mem_re`=0, `mem_addr`=0, `busy`=0, `done`=0, `vector_out`=0.
- Cycle 0 is the cycle in which `start` is sampled.
  - `busy` is high from cycle 1.
  - With `mem_ready` held at 1, requests go out in cycles 1..N and data is captured in cycles 2..N+1.
  - `done` pulses and `vector_out` is valid in cycle N+2; `busy` falls in cycle N+3.
- Full load latency is 18 cycles (start to `done`); broadcast latency is 3 cycles.
- Each cycle with `mem_ready`=0 during issue adds exactly one cycle to latency.
- The earliest next `start` is accepted in cycle N+3, giving a back-to-back throughput of one vector per N+3 cycles.

## Structure
- Shared package `vec_pkg`: `ELEMENT`/`WIDTH` constants, `vec_t` typedef (`logic [ELEMENT-1:0][WIDTH-1:0]`) shared with `alu_vec`, and the state enum `vld_state_t`.
- One natural sub-module: `vec_addr_gen`. It owns the base/stride latch, the wrapping accumulator and issue_cnt, and outputs `mem_addr` and "last issued". The FSM, capture logic and shadow buffer stay in the top module.

## Test plan
- Full load: memory[0x100+i]=0x1000+i, `start` with base 0x100, stride 1, `bcast`=0 → `done` at cycle 18, `vector_out[i]`=0x1000+i, `mem_addr` sequence 0x100..0x10F.
- Broadcast: memory[0x40]=0x0064, `bcast`=1 → one request, `done` at cycle 3, all lanes 0x0064; the result feeds an ALU add against a known vector and the sum is checked.
- Stride wrap: base 0xFFF0, stride 0x0004 → addresses 0xFFF0, 0xFFF4, 0xFFF8, 0xFFFC, 0x0000, …, 0x002C; lanes hold the matching memory words.
- Back-pressure: `mem_ready` low for 3 cycles starting at cycle 5 → `mem_addr` frozen at base+4 during the stall, `done` at cycle 21, data identical to the no-stall case.
- `start` pulsed at cycle 7 with a different base → ignored; result equals the first load. `vector_out` is unchanged before `done`.
- `rst_n` asserted at cycle 9 → `busy`/`mem_re`/`done` go to 0 immediately and `vector_out`=0. A fresh `start` after release completes correctly with no stale lanes.
